bram_loader: RTL and testbench

- Boot-time loader that fills any of NUM_MEMS BRAM32 instances (instruction, data, …) from a valid/ready word stream.
- It then releases the CPU by dropping cpu_stall, replacing the ad-hoc bench-driven write sequencing with a reusable sequenced block.
- Sits between the host/UART word source and the BRAM write ports; holds the PC stalled until every segment is committed.

---
 rtl/bram_loader_pkg.sv | 37 +++
 rtl/bram_loader_if.sv | 25 ++
 rtl/bram_loader_write_stage.sv | 73 +++++++
 rtl/bram_loader.sv | 107 ++++++++++
 tb/tb_bram_loader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_loader_pkg.sv
// Shared state encodings, header field layout and memory ids for the boot-time BRAM loader.
package bram_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_HEADER = 3'd1,
        LDR_BASE   = 3'd2,
        LDR_DATA   = 3'd3,
        LDR_FLUSH  = 3'd4,
        LDR_DONE   = 3'd5,
        LDR_ERROR  = 3'd6
    } ldr_state_e;

    // Top byte of a header word carries last_seg plus a 7-bit memory id.
    localparam int LDR_TAG_W = 8;
    localparam int LDR_ID_W  = 7;

    localparam int MEM_ID_INSTR = 0;
    localparam int MEM_ID_DATA  = 1;

    function automatic int ldr_last_bit(input int dw);
        return dw - 1;
    endfunction

    function automatic int ldr_id_msb(input int dw);
        return dw - 2;
    endfunction

    function automatic int ldr_id_lsb(input int dw);
        return dw - LDR_TAG_W;
    endfunction

    function automatic int ldr_cnt_msb(input int dw);
        return dw - LDR_TAG_W - 1;
    endfunction

endpackage

// File: rtl/bram_loader_if.sv
// Word stream in and BRAM write port out; master is the loader, slave is the host/memory side.
interface bram_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_MEMS   = 2
);
    logic                      s_valid;
    logic                      s_ready;
    logic [DATA_WIDTH-1:0]     s_data;
    logic [NUM_MEMS-1:0]       mem_sel;
    logic [ADDR_WIDTH-1:0]     w_addr;
    logic [DATA_WIDTH-1:0]     w_dat;
    logic                      w_enb;
    logic [DATA_WIDTH/8-1:0]   byte_enb;

    modport master (
        input  s_valid, s_data,
        output s_ready, mem_sel, w_addr, w_dat, w_enb, byte_enb
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, mem_sel, w_addr, w_dat, w_enb, byte_enb
    );
endinterface

// File: rtl/bram_loader_write_stage.sv
// Registered BRAM write port: word address counter plus one-cycle write pulse per accepted word.
module ldr_write_stage
    import bram_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_MEMS   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0] i_base_word,
    input  logic                     i_acc,
    input  logic [LDR_ID_W-1:0]      i_mem_id,
    input  logic [DATA_WIDTH-1:0]    i_data,
    output logic [NUM_MEMS-1:0]      o_mem_sel,
    output logic [ADDR_WIDTH-1:0]    o_addr,
    output logic [DATA_WIDTH-1:0]    o_dat,
    output logic                     o_enb,
    output logic [DATA_WIDTH/8-1:0]  o_byte_enb
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFS_W = $clog2(BE_W);
    localparam int WA_W  = ADDR_WIDTH - OFS_W;

    logic [WA_W-1:0]       r_wptr;
    logic [NUM_MEMS-1:0]   w_onehot;
    logic [NUM_MEMS-1:0]   r_mem_sel_p1;
    logic [ADDR_WIDTH-1:0] r_addr_p1;
    logic [DATA_WIDTH-1:0] r_dat_p1;
    logic                  r_enb_p1;

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_MEMS; i++) begin
            if (int'(i_mem_id) == i) w_onehot[i] = 1'b1;
        end
    end

    // Pointer runs in word units; the BASE check guarantees it never leaves the memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
        end else if (i_load) begin
            r_wptr <= i_base_word;
        end else if (i_acc) begin
            r_wptr <= r_wptr + WA_W'(1);
        end
    end

    // accept -> write port, one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enb_p1     <= 1'b0;
            r_mem_sel_p1 <= '0;
            r_addr_p1    <= '0;
            r_dat_p1     <= '0;
        end else begin
            r_enb_p1     <= i_acc;
            r_mem_sel_p1 <= i_acc ? w_onehot : '0;
            if (i_acc) begin
                r_addr_p1 <= ADDR_WIDTH'(r_wptr) << OFS_W;
                r_dat_p1  <= i_data;
            end
        end
    end

    assign o_enb      = r_enb_p1;
    assign o_mem_sel  = r_mem_sel_p1;
    assign o_addr     = r_addr_p1;
    assign o_dat      = r_dat_p1;
    assign o_byte_enb = {BE_W{r_enb_p1}};
endmodule

// File: rtl/bram_loader.sv
// Boot loader: parses header/base/data segments from a word stream into BRAM writes and holds the CPU until done.
module bram_loader
    import bram_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_MEMS   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    bram_loader_if.master bus,
    output logic          cpu_stall,
    output logic          init_done,
    output logic          busy,
    output logic          error
);
    localparam int BE_W     = DATA_WIDTH / 8;
    localparam int OFS_W    = $clog2(BE_W);
    localparam int WA_W     = ADDR_WIDTH - OFS_W;
    localparam int DEPTH    = 1 << WA_W;
    localparam int CNT_W    = ldr_cnt_msb(DATA_WIDTH) + 1;
    localparam int LAST_BIT = ldr_last_bit(DATA_WIDTH);
    localparam int ID_MSB   = ldr_id_msb(DATA_WIDTH);
    localparam int ID_LSB   = ldr_id_lsb(DATA_WIDTH);

    ldr_state_e            r_state, w_next;
    logic                  r_last;
    logic [LDR_ID_W-1:0]   r_mem_id;
    logic [CNT_W-1:0]      r_cnt, r_n;

    logic                  w_acc, w_hdr_bad, w_base_bad, w_seg_end;
    logic [LDR_ID_W-1:0]   w_hdr_id;
    logic [CNT_W-1:0]      w_hdr_cnt;
    logic [DATA_WIDTH:0]   w_base_end;

    assign bus.s_ready = (r_state == LDR_HEADER) || (r_state == LDR_BASE) || (r_state == LDR_DATA);
    assign w_acc       = bus.s_valid & bus.s_ready;

    assign w_hdr_id   = bus.s_data[ID_MSB:ID_LSB];
    assign w_hdr_cnt  = bus.s_data[CNT_W-1:0];
    assign w_hdr_bad  = (int'(w_hdr_id) >= NUM_MEMS) || (w_hdr_cnt == '0);
    // Bound check is done one bit wider than the word so a huge base cannot wrap past it.
    assign w_base_end = (DATA_WIDTH+1)'(bus.s_data >> OFS_W) + (DATA_WIDTH+1)'(r_cnt);
    assign w_base_bad = ((bus.s_data & DATA_WIDTH'(BE_W - 1)) != '0)
                     || (w_base_end > (DATA_WIDTH+1)'(DEPTH));
    assign w_seg_end  = (r_n == r_cnt - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= LDR_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            LDR_IDLE, LDR_DONE, LDR_ERROR: if (start) w_next = LDR_HEADER;
            LDR_HEADER: if (w_acc) w_next = w_hdr_bad ? LDR_ERROR : LDR_BASE;
            LDR_BASE:   if (w_acc) w_next = w_base_bad ? LDR_ERROR : LDR_DATA;
            LDR_DATA:   if (w_acc && w_seg_end) w_next = r_last ? LDR_FLUSH : LDR_HEADER;
            LDR_FLUSH:  w_next = LDR_DONE;
            default:    w_next = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= 1'b0;
            r_mem_id <= '0;
            r_cnt    <= '0;
            r_n      <= '0;
        end else if (w_acc) begin
            if (r_state == LDR_HEADER) begin
                r_last   <= bus.s_data[LAST_BIT];
                r_mem_id <= w_hdr_id;
                r_cnt    <= w_hdr_cnt;
            end
            if (r_state == LDR_BASE) r_n <= '0;
            if (r_state == LDR_DATA) r_n <= r_n + CNT_W'(1);
        end
    end

    ldr_write_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_MEMS   (NUM_MEMS)
    ) u_wstage (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_acc && (r_state == LDR_BASE)),
        .i_base_word (bus.s_data[OFS_W +: WA_W]),
        .i_acc       (w_acc && (r_state == LDR_DATA)),
        .i_mem_id    (r_mem_id),
        .i_data      (bus.s_data),
        .o_mem_sel   (bus.mem_sel),
        .o_addr      (bus.w_addr),
        .o_dat       (bus.w_dat),
        .o_enb       (bus.w_enb),
        .o_byte_enb  (bus.byte_enb)
    );

    assign cpu_stall = (r_state != LDR_DONE);
    assign init_done = (r_state == LDR_DONE);
    assign error     = (r_state == LDR_ERROR);
    assign busy      = (r_state == LDR_HEADER) || (r_state == LDR_BASE)
                    || (r_state == LDR_DATA)   || (r_state == LDR_FLUSH);
endmodule

// File: tb/tb_bram_loader.sv
// Scoreboard bench for bram_loader: stimulus queues expected writes, a monitor checks every write pulse.
module tb_bram_loader;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_stall, init_done, busy, error;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]  sel;
        logic [11:0] addr;
        logic [31:0] dat;
    } wr_t;

    wr_t exp_q[$];

    bram_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_MEMS(2)) bus ();

    bram_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_MEMS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .cpu_stall (cpu_stall),
        .init_done (init_done),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [1:0] sel, input logic [11:0] addr, input logic [31:0] dat);
        wr_t e;
        e.sel = sel; e.addr = addr; e.dat = dat;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge just after the word transferred.
    task automatic send(input logic [31:0] d);
        int k;
        k = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (!bus.s_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.s_ready) begin
            total++; bad++;
            $display("FAIL send_timeout act=not_ready exp=ready data=%h", d);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic bubble(input int n);
        bus.s_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_error_state(input string name);
        chk({name, "_error"}, 64'(error), 64'd1);
        chk({name, "_stall"}, 64'(cpu_stall), 64'd1);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_ready"}, 64'(bus.s_ready), 64'd0);
        chk({name, "_wenb"}, 64'(bus.w_enb), 64'd0);
    endtask

    // Monitor: every write pulse must match the head of the expectation queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.w_enb === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write act=sel%b@%h:%h exp=none", bus.mem_sel, bus.w_addr, bus.w_dat);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.mem_sel !== e.sel || bus.w_addr !== e.addr || bus.w_dat !== e.dat || bus.byte_enb !== 4'hF) begin
                        bad++;
                        $display("FAIL write act=sel%b@%h:%h be%h exp=sel%b@%h:%h beF",
                                 bus.mem_sel, bus.w_addr, bus.w_dat, bus.byte_enb, e.sel, e.addr, e.dat);
                    end
                end
            end else if (bus.mem_sel !== 2'b00 || bus.byte_enb !== 4'h0) begin
                total++; bad++;
                $display("FAIL idle_strobes act=sel%b be%h exp=sel00 be0", bus.mem_sel, bus.byte_enb);
            end
        end
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 64'(cpu_stall), 64'd1);
        chk("rst_done", 64'(init_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_wenb", 64'(bus.w_enb), 64'd0);
        chk("rst_ready", 64'(bus.s_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'(bus.s_ready), 64'd0);

        // Single segment to instruction memory
        pulse_start();
        chk("t1_busy", 64'(busy), 64'd1);
        send(32'h8000_0003);
        send(32'h0000_0000);
        expect_wr(2'b01, 12'h000, 32'hAAAA_0001); send(32'hAAAA_0001);
        expect_wr(2'b01, 12'h004, 32'hBBBB_0002); send(32'hBBBB_0002);
        expect_wr(2'b01, 12'h008, 32'hCCCC_0003); send(32'hCCCC_0003);
        chk("t1_flush_wenb", 64'(bus.w_enb), 64'd1);
        chk("t1_flush_done", 64'(init_done), 64'd0);
        chk("t1_flush_stall", 64'(cpu_stall), 64'd1);
        @(negedge clk);
        chk("t1_done", 64'(init_done), 64'd1);
        chk("t1_stall", 64'(cpu_stall), 64'd0);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_ready_end", 64'(bus.s_ready), 64'd0);

        // start in DONE reloads
        pulse_start();
        chk("t2_restart_stall", 64'(cpu_stall), 64'd1);
        chk("t2_restart_done", 64'(init_done), 64'd0);
        chk("t2_restart_busy", 64'(busy), 64'd1);

        // Two segments: data memory then instruction memory; start while busy is ignored
        send(32'h0100_0002);
        send(32'h0000_0000);
        pulse_start();
        chk("t2_start_ignored_busy", 64'(busy), 64'd1);
        chk("t2_start_ignored_ready", 64'(bus.s_ready), 64'd1);
        expect_wr(2'b10, 12'h000, 32'h0000_0005); send(32'h0000_0005);
        expect_wr(2'b10, 12'h004, 32'h0000_0003); send(32'h0000_0003);
        chk("t2_mid_done", 64'(init_done), 64'd0);
        send(32'h8000_0005);
        send(32'h0000_0000);
        expect_wr(2'b01, 12'h000, 32'h0000_2083); send(32'h0000_2083);
        expect_wr(2'b01, 12'h004, 32'h0040_2103); send(32'h0040_2103);
        expect_wr(2'b01, 12'h008, 32'h4020_8A33); send(32'h4020_8A33);
        expect_wr(2'b01, 12'h00C, 32'h0140_2623); send(32'h0140_2623);
        expect_wr(2'b01, 12'h010, 32'h0000_006F); send(32'h0000_006F);
        @(negedge clk);
        chk("t2_done", 64'(init_done), 64'd1);
        chk("t2_stall", 64'(cpu_stall), 64'd0);

        // Bubbles inside DATA
        pulse_start();
        send(32'h8000_0003);
        bubble(1);
        send(32'h0000_0010);
        expect_wr(2'b01, 12'h010, 32'h1111_1111); send(32'h1111_1111);
        bubble(2);
        expect_wr(2'b01, 12'h014, 32'h2222_2222); send(32'h2222_2222);
        bubble(1);
        chk("t3_bubble_busy", 64'(busy), 64'd1);
        expect_wr(2'b01, 12'h018, 32'h3333_3333); send(32'h3333_3333);
        @(negedge clk);
        chk("t3_done", 64'(init_done), 64'd1);

        // Errors: bad mem_id, unaligned base, range overflow
        pulse_start();
        send(32'h8200_0001);
        chk_error_state("e1");
        bubble(2);
        chk("e1_hold", 64'(error), 64'd1);
        pulse_start();
        chk("e2_cleared", 64'(error), 64'd0);
        send(32'h8000_0001);
        send(32'h0000_0002);
        chk_error_state("e2");
        bubble(1);
        pulse_start();
        send(32'h8000_0002);
        send(32'h0000_0FFC);
        chk_error_state("e3");
        bubble(1);
        pulse_start();
        chk("e4_cleared", 64'(error), 64'd0);
        send(32'h8000_0002);
        send(32'h0000_0FF8);
        expect_wr(2'b01, 12'hFF8, 32'hDEAD_BEEF); send(32'hDEAD_BEEF);
        expect_wr(2'b01, 12'hFFC, 32'hCAFE_F00D); send(32'hCAFE_F00D);
        @(negedge clk);
        chk("e4_done", 64'(init_done), 64'd1);
        chk("e4_error", 64'(error), 64'd0);

        // Reset mid-DATA after two of four words
        pulse_start();
        send(32'h0100_0004);
        send(32'h0000_0020);
        expect_wr(2'b10, 12'h020, 32'h0000_00A1); send(32'h0000_00A1);
        expect_wr(2'b10, 12'h024, 32'h0000_00A2); send(32'h0000_00A2);
        #1;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h0000_00A3;
        rst = 1'b1;
        #1;
        chk("r_wenb", 64'(bus.w_enb), 64'd0);
        chk("r_sel", 64'(bus.mem_sel), 64'd0);
        chk("r_stall", 64'(cpu_stall), 64'd1);
        chk("r_busy", 64'(busy), 64'd0);
        chk("r_ready", 64'(bus.s_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("r_after_busy", 64'(busy), 64'd0);
        chk("r_after_done", 64'(init_done), 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
